// File: rtl/sipo_frame_rx.sv
// Serial-to-parallel framing receiver: start bit, WIDTH data bits, valid/ready output.
// Define SIPO_FRAME_RX_PARITY_EN to receive a trailing even-parity bit and drive PERR.
module sipo_frame_rx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SIN,
  input  logic             SEN,
  output logic [WIDTH-1:0] DOUT,
  output logic             DVALID,
  input  logic             DREADY,
  output logic             BUSY,
  output logic             OVERRUN,
  output logic             PERR
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

`ifdef SIPO_FRAME_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PAR = 2'd2} state_t;

  function automatic logic parity_err(input logic [WIDTH-1:0] word, input logic par_bit);
    return (^word) ^ par_bit;
  endfunction
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1} state_t;
`endif

  state_t           state_r, state_next_s;
  logic [CW-1:0]    cnt_r, cnt_next_s;
  logic [WIDTH-1:0] shift_r, shift_next_s, shifted_s, word_s;
  logic [WIDTH-1:0] dout_r;
  logic             dvalid_r, busy_r, overrun_r, perr_r;
  logic             complete_s, perr_new_s;

  // The final data bit is merged here so the word loads on the edge that samples it.
  assign shifted_s = MSB_FIRST ? {shift_r[WIDTH-2:0], SIN} : {SIN, shift_r[WIDTH-1:1]};

  // Next-state, bit counter and frame-completion decode.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    shift_next_s = shift_r;
    complete_s   = 1'b0;
    word_s       = shift_r;
    perr_new_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (SEN && SIN) begin
          state_next_s = DATA;
          cnt_next_s   = '0;
        end else begin
          state_next_s = IDLE;
        end
      end
      DATA: begin
        if (SEN) begin
          shift_next_s = shifted_s;
          if (cnt_r == LAST_CNT) begin
            cnt_next_s = '0;
`ifdef SIPO_FRAME_RX_PARITY_EN
            state_next_s = PAR;
`else
            state_next_s = IDLE;
            complete_s   = 1'b1;
            word_s       = shifted_s;
`endif
          end else begin
            cnt_next_s = cnt_r + CW'(1);
          end
        end else begin
          state_next_s = DATA;
        end
      end
`ifdef SIPO_FRAME_RX_PARITY_EN
      PAR: begin
        if (SEN) begin
          state_next_s = IDLE;
          complete_s   = 1'b1;
          word_s       = shift_r;
          perr_new_s   = parity_err(shift_r, SIN);
        end else begin
          state_next_s = PAR;
        end
      end
`endif
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = '0;
      end
    endcase
  end

  // State, shift register and output handshake registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      shift_r   <= '0;
      busy_r    <= 1'b0;
      dout_r    <= '0;
      dvalid_r  <= 1'b0;
      overrun_r <= 1'b0;
      perr_r    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      shift_r <= shift_next_s;
      busy_r  <= (state_next_s != IDLE);
      if (complete_s) begin
        // A held, unaccepted word wins; the new one is dropped and flagged.
        if (dvalid_r && !DREADY) begin
          overrun_r <= 1'b1;
        end else begin
          dout_r   <= word_s;
          dvalid_r <= 1'b1;
          perr_r   <= perr_new_s;
        end
      end else if (dvalid_r && DREADY) begin
        dvalid_r <= 1'b0;
      end else begin
        dvalid_r <= dvalid_r;
      end
    end
  end

  assign DOUT    = dout_r;
  assign DVALID  = dvalid_r;
  assign BUSY    = busy_r;
  assign OVERRUN = overrun_r;
  assign PERR    = perr_r;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Scoreboard bench for sipo_frame_rx (WIDTH=8, LSB first); stimulus queues expected words,
// a negedge monitor pops and compares them on every DVALID&&DREADY transfer.
module tb_sipo_frame_rx;

  localparam int W = 8;
`ifdef SIPO_FRAME_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic         CLK = 1'b0;
  logic         RST, SIN, SEN, DREADY;
  logic [W-1:0] DOUT;
  logic         DVALID, BUSY, OVERRUN, PERR;

  sipo_frame_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut (
    .CLK(CLK), .RST(RST), .SIN(SIN), .SEN(SEN), .DOUT(DOUT), .DVALID(DVALID),
    .DREADY(DREADY), .BUSY(BUSY), .OVERRUN(OVERRUN), .PERR(PERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [W-1:0] d;
    logic         p;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   dvalid_cnt = 0;
  int   rise_cyc = 0;
  logic prev_valid = 1'b0;

  initial begin
    forever begin
      @(posedge CLK);
      cyc = cyc + 1;
    end
  end

  // Monitor: activity counters plus scoreboard compare on each transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (BUSY === 1'b1) busy_cnt = busy_cnt + 1;
      if (DVALID === 1'b1) dvalid_cnt = dvalid_cnt + 1;
      if (DVALID === 1'b1 && !prev_valid) rise_cyc = cyc;
      prev_valid = (DVALID === 1'b1);
      if (DVALID === 1'b1 && DREADY === 1'b1) begin
        checks = checks + 1;
        if (sb.size() == 0) begin
          errors = errors + 1;
          $display("FAIL sb_unexpected: got DOUT=%h PERR=%b, required no transfer", DOUT, PERR);
        end else begin
          e = sb.pop_front();
          if (DOUT !== e.d || PERR !== e.p) begin
            errors = errors + 1;
            $display("FAIL sb_word: got DOUT=%h PERR=%b, required DOUT=%h PERR=%b",
                     DOUT, PERR, e.d, e.p);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic exp_perr(input logic [W-1:0] w, input logic p);
    if (PB == 1) return (^w) ^ p;
    else return 1'b0;
  endfunction

  task automatic push_exp(input logic [W-1:0] w, input logic p);
    exp_t e;
    e.d = w;
    e.p = exp_perr(w, p);
    sb.push_back(e);
  endtask

  // Start bit, LSB-first data, optional 3-cycle stall (SIN=1 while stalled), optional abort,
  // optional DREADY raise on the frame's final bit.
  task automatic send_frame(input logic [W-1:0] w, input logic p, input int stall_after,
                            input int abort_after, input bit ready_last);
    SEN = 1'b1; SIN = 1'b1; tick();
    for (int i = 0; i < W; i++) begin
      if (i == abort_after) begin
        SEN = 1'b0; SIN = 1'b0;
        return;
      end
      if (ready_last && i == W - 1 && PB == 0) DREADY = 1'b1;
      SEN = 1'b1; SIN = w[i]; tick();
      if (i == stall_after) begin
        SEN = 1'b0; SIN = 1'b1;
        repeat (3) tick();
      end
    end
    if (PB == 1) begin
      if (ready_last) DREADY = 1'b1;
      SEN = 1'b1; SIN = p; tick();
    end
    SEN = 1'b0; SIN = 1'b0;
  endtask

  initial begin
    int s, b0, d0;
    RST = 1'b1; SEN = 1'b0; SIN = 1'b0; DREADY = 1'b0;
    repeat (2) tick();
    chk("rst_dout", DOUT, 8'h00);
    chk("rst_dvalid", DVALID, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_overrun", OVERRUN, 1'b0);
    chk("rst_perr", PERR, 1'b0);
    RST = 1'b0; DREADY = 1'b1;
    tick();

    // single frame, zero latency after the last bit
    b0 = busy_cnt; d0 = dvalid_cnt; s = cyc;
    push_exp(8'hA5, ^8'hA5);
    send_frame(8'hA5, ^8'hA5, -1, -1, 1'b0);
    chk("single_dvalid_now", DVALID, 1'b1);
    chk("single_dout_now", DOUT, 8'hA5);
    repeat (2) tick();
    chk("single_busy_cycles", busy_cnt - b0, 8 + PB);
    chk("single_dvalid_cycles", dvalid_cnt - d0, 1);
    chk("single_rise_cycle", rise_cyc - s, 9 + PB);
    chk("single_overrun", OVERRUN, 1'b0);

    // stall after data bit 4
    s = cyc;
    push_exp(8'hA5, ^8'hA5);
    send_frame(8'hA5, ^8'hA5, 3, -1, 1'b0);
    repeat (2) tick();
    chk("stall_rise_cycle", rise_cyc - s, 12 + PB);

    // overrun: second frame dropped, with bad parity that must not leak to PERR
    DREADY = 1'b0;
    push_exp(8'hA5, ^8'hA5);
    send_frame(8'hA5, ^8'hA5, -1, -1, 1'b0);
    chk("ovr_before", OVERRUN, 1'b0);
    send_frame(8'h3C, ~(^8'h3C), -1, -1, 1'b0);
    chk("ovr_dout", DOUT, 8'hA5);
    chk("ovr_dvalid", DVALID, 1'b1);
    chk("ovr_flag", OVERRUN, 1'b1);
    chk("ovr_perr", PERR, 1'b0);
    DREADY = 1'b1; tick(); DREADY = 1'b0;
    chk("ovr_drain_dvalid", DVALID, 1'b0);
    chk("ovr_sticky", OVERRUN, 1'b1);
    RST = 1'b1; tick(); RST = 1'b0;
    chk("ovr_cleared", OVERRUN, 1'b0);

    // accept and complete on the same edge
    push_exp(8'h11, ^8'h11);
    send_frame(8'h11, ^8'h11, -1, -1, 1'b0);
    chk("sim_hold_dvalid", DVALID, 1'b1);
    push_exp(8'h22, ^8'h22);
    send_frame(8'h22, ^8'h22, -1, -1, 1'b1);
    chk("sim_dout", DOUT, 8'h22);
    chk("sim_dvalid", DVALID, 1'b1);
    chk("sim_overrun", OVERRUN, 1'b0);
    tick();

    // reset mid-frame discards the partial word
    DREADY = 1'b1; d0 = dvalid_cnt;
    send_frame(8'h1F, 1'b0, -1, 5, 1'b0);
    chk("rstmid_busy_before", BUSY, 1'b1);
    RST = 1'b1; tick(); RST = 1'b0;
    chk("rstmid_busy", BUSY, 1'b0);
    tick();
    chk("rstmid_no_dvalid", dvalid_cnt - d0, 0);
    push_exp(8'hFF, ^8'hFF);
    send_frame(8'hFF, ^8'hFF, -1, -1, 1'b0);
    chk("rstmid_next_dout", DOUT, 8'hFF);
    repeat (2) tick();

    // back-to-back frames, start bit right after completion
    push_exp(8'h5A, ^8'h5A);
    push_exp(8'hC3, ^8'hC3);
    send_frame(8'h5A, ^8'h5A, -1, -1, 1'b0);
    send_frame(8'hC3, ^8'hC3, -1, -1, 1'b0);
    chk("b2b_dout", DOUT, 8'hC3);
    repeat (2) tick();

`ifdef SIPO_FRAME_RX_PARITY_EN
    push_exp(8'hA5, 1'b0);
    send_frame(8'hA5, 1'b0, -1, -1, 1'b0);
    chk("par_good_perr", PERR, 1'b0);
    push_exp(8'hA5, 1'b1);
    send_frame(8'hA5, 1'b1, -1, -1, 1'b0);
    chk("par_bad_perr", PERR, 1'b1);
    chk("par_bad_dout", DOUT, 8'hA5);
    repeat (2) tick();
`endif

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
